// File: rtl/axi4_lite_register_slave_pkg.sv
// axi_lite_slave_pkg: response codes and FSM state types shared by the register slave
package axi_lite_slave_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DELAY, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} rd_state_t;
endpackage

// File: rtl/axi4_lite_register_slave_if.sv
// axi4_lite_if: AXI4-Lite AW/W/B/AR/R channel bundle with 32-bit address and data
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_register_slave_decoder.sv
// Register_Addr_Decoder: maps a byte address onto a register index with range and read-only flags
module Register_Addr_Decoder #(
  parameter logic [31:0]          BASE_ADDR = 32'h0000_1000,
  parameter int                   REG_COUNT = 16,
  parameter logic [REG_COUNT-1:0] RO_MASK   = '0
) (
  input  logic [31:0]                  addr,
  output logic [$clog2(REG_COUNT)-1:0] index,
  output logic                         in_range,
  output logic                         is_ro
);
  localparam int IW = $clog2(REG_COUNT);
  logic [31:0] w_off;
  assign w_off    = addr - BASE_ADDR;
  assign in_range = (addr >= BASE_ADDR) && (w_off < 32'(REG_COUNT * 4));
  assign index    = w_off[IW+1:2];
  assign is_ro    = RO_MASK[index];
endmodule

// File: rtl/axi4_lite_register_slave.sv
// axi4_lite_register_slave: AXI4-Lite register bank with read-only status mapping, byte strobes and response delay
module axi4_lite_register_slave
  import axi_lite_slave_pkg::*;
#(
  parameter logic [31:0]          BASE_ADDR  = 32'h0000_1000,
  parameter int                   REG_COUNT  = 16,
  parameter logic [REG_COUNT-1:0] RO_MASK    = '0,
  parameter int                   RESP_DELAY = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  axi4_lite_if.slave                  axi,
  output logic [0:REG_COUNT-1][31:0]  reg_out,
  input  logic [0:REG_COUNT-1][31:0]  reg_in,
  output logic [REG_COUNT-1:0]        wr_pulse,
  output logic [REG_COUNT-1:0]        rd_pulse
);
  localparam int         IW  = $clog2(REG_COUNT);
  localparam logic [7:0] DLY = 8'(RESP_DELAY);
  wr_state_t                 r_wr_st;
  rd_state_t                 r_rd_st;
  logic                      r_awrdy, r_wrdy, r_arrdy, r_bvalid, r_rvalid, r_aw_held, r_w_held;
  logic [1:0]                r_bresp, r_rresp;
  logic [31:0]               r_awaddr, r_wdata, r_rdata;
  logic [3:0]                r_wstrb;
  logic [7:0]                r_wcnt, r_rcnt;
  logic [0:REG_COUNT-1][31:0] r_regs;
  logic [REG_COUNT-1:0]      r_wr_pulse, r_rd_pulse, r_rd_mask;
  logic                      w_aw_hs, w_w_hs, w_ar_hs, w_aw_have, w_w_have, w_commit, w_wr_ok;
  logic                      w_aw_in, w_aw_ro, w_ar_in, w_ar_ro;
  logic [31:0]               w_awaddr, w_wdata, w_rd_word;
  logic [3:0]                w_wstrb;
  logic [IW-1:0]             w_aw_idx, w_ar_idx;
  logic [REG_COUNT-1:0]      w_ar_mask;

  assign w_aw_hs   = axi.awvalid && r_awrdy;
  assign w_w_hs    = axi.wvalid && r_wrdy;
  assign w_ar_hs   = axi.arvalid && r_arrdy;
  assign w_aw_have = r_aw_held || w_aw_hs;
  assign w_w_have  = r_w_held || w_w_hs;
  assign w_commit  = (r_wr_st == W_IDLE) && w_aw_have && w_w_have;
  assign w_awaddr  = r_aw_held ? r_awaddr : axi.awaddr;
  assign w_wdata   = r_w_held ? r_wdata : axi.wdata;
  assign w_wstrb   = r_w_held ? r_wstrb : axi.wstrb;
  assign w_wr_ok   = w_aw_in && !w_aw_ro;
  assign w_ar_mask = w_ar_in ? (REG_COUNT'(1) << w_ar_idx) : '0;
  assign w_rd_word = !w_ar_in ? 32'h0 : w_ar_ro ? reg_in[w_ar_idx] : r_regs[w_ar_idx];

  Register_Addr_Decoder #(.BASE_ADDR(BASE_ADDR), .REG_COUNT(REG_COUNT), .RO_MASK(RO_MASK)) u_aw_dec (
    .addr(w_awaddr), .index(w_aw_idx), .in_range(w_aw_in), .is_ro(w_aw_ro)
  );
  Register_Addr_Decoder #(.BASE_ADDR(BASE_ADDR), .REG_COUNT(REG_COUNT), .RO_MASK(RO_MASK)) u_ar_dec (
    .addr(axi.araddr), .index(w_ar_idx), .in_range(w_ar_in), .is_ro(w_ar_ro)
  );

  // Write channel FSM: collect AW and W in any order, commit, optional delay, hold B until accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_st   <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awrdy   <= 1'b0;
      r_wrdy    <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_wcnt    <= '0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else
      case (r_wr_st)
        W_IDLE:
          if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awrdy   <= 1'b0;
            r_wrdy    <= 1'b0;
            r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            r_wcnt    <= DLY;
            r_wr_st   <= DLY != 0 ? W_DELAY : W_RESP;
            r_bvalid  <= DLY == 0;
          end else begin
            if (w_aw_hs) begin
              r_aw_held <= 1'b1;
              r_awaddr  <= axi.awaddr;
            end
            if (w_w_hs) begin
              r_w_held <= 1'b1;
              r_wdata  <= axi.wdata;
              r_wstrb  <= axi.wstrb;
            end
            r_awrdy <= !w_aw_have;
            r_wrdy  <= !w_w_have;
          end
        W_DELAY: begin
          r_wcnt <= r_wcnt - 8'd1;
          if (r_wcnt == 8'd1) begin
            r_wr_st  <= W_RESP;
            r_bvalid <= 1'b1;
          end
        end
        W_RESP:
          if (axi.bready) begin
            r_bvalid <= 1'b0;
            r_awrdy  <= 1'b1;
            r_wrdy   <= 1'b1;
            r_wr_st  <= W_IDLE;
          end
        default: r_wr_st <= W_IDLE;
      endcase

  // Register array: byte-lane merge on a committed writable, non-empty-strobe write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_regs     <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && w_wr_ok && |w_wstrb) begin
        for (int k = 0; k < 4; k++)
          if (w_wstrb[k]) r_regs[w_aw_idx][8*k +: 8] <= w_wdata[8*k +: 8];
        r_wr_pulse[w_aw_idx] <= 1'b1;
      end
    end

  // Read channel FSM: capture data at the AR handshake, optional delay, hold R until accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd_st    <= R_IDLE;
      r_arrdy    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_rcnt     <= '0;
      r_rd_mask  <= '0;
      r_rd_pulse <= '0;
    end else begin
      r_rd_pulse <= '0;
      case (r_rd_st)
        R_IDLE:
          if (w_ar_hs) begin
            r_arrdy    <= 1'b0;
            r_rdata    <= w_rd_word;
            r_rresp    <= w_ar_in ? RESP_OKAY : RESP_SLVERR;
            r_rd_mask  <= w_ar_mask;
            r_rcnt     <= DLY;
            r_rd_st    <= DLY != 0 ? R_DELAY : R_RESP;
            r_rvalid   <= DLY == 0;
            r_rd_pulse <= DLY == 0 ? w_ar_mask : '0;
          end else
            r_arrdy <= 1'b1;
        R_DELAY: begin
          r_rcnt <= r_rcnt - 8'd1;
          if (r_rcnt == 8'd1) begin
            r_rd_st    <= R_RESP;
            r_rvalid   <= 1'b1;
            r_rd_pulse <= r_rd_mask;
          end
        end
        R_RESP:
          if (axi.rready) begin
            r_rvalid <= 1'b0;
            r_arrdy  <= 1'b1;
            r_rd_st  <= R_IDLE;
          end
        default: r_rd_st <= R_IDLE;
      endcase
    end

  assign axi.awready = r_awrdy;
  assign axi.wready  = r_wrdy;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.arready = r_arrdy;
  assign axi.rvalid  = r_rvalid;
  assign axi.rresp   = r_rresp;
  assign axi.rdata   = r_rdata;
  assign reg_out     = r_regs;
  assign wr_pulse    = r_wr_pulse;
  assign rd_pulse    = r_rd_pulse;
endmodule

// File: tb/tb_axi4_lite_register_slave.sv
// tb_axi4_lite_register_slave: scoreboard bench for the AXI4-Lite register slave (no-delay and delayed instances)
module tb_axi4_lite_register_slave;
  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  logic [0:15][31:0] ro0, ri0, ro1, ri1;
  logic [15:0] wp0, rp0, wp1, rp1;
  int nchk = 0;
  int nerr = 0;
  int wp_cnt [16];
  int rp_cnt [16];
  logic [33:0] rq [$];
  logic [1:0]  bq [$];

  axi4_lite_if m0();
  axi4_lite_if m1();

  axi4_lite_register_slave #(.RO_MASK(16'h0004)) u0 (
    .clk(clk), .rst_n(rst0_n), .axi(m0), .reg_out(ro0), .reg_in(ri0), .wr_pulse(wp0), .rd_pulse(rp0)
  );
  axi4_lite_register_slave #(.RESP_DELAY(200)) u1 (
    .clk(clk), .rst_n(rst1_n), .axi(m1), .reg_out(ro1), .reg_in(ri1), .wr_pulse(wp1), .rd_pulse(rp1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // response scoreboard and pulse-width counters for the no-delay instance
  always @(negedge clk) begin
    if (m0.rvalid && m0.rready) begin
      chk("r_expected", rq.size() != 0, 1);
      if (rq.size() != 0) chk("r_resp_data", {m0.rresp, m0.rdata}, rq.pop_front());
    end
    if (m0.bvalid && m0.bready) begin
      chk("b_expected", bq.size() != 0, 1);
      if (bq.size() != 0) chk("b_resp", m0.bresp, bq.pop_front());
    end
    for (int i = 0; i < 16; i++) begin
      wp_cnt[i] += int'(wp0[i]);
      rp_cnt[i] += int'(rp0[i]);
    end
  end

  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    m0.awaddr = a;
    m0.awvalid = 1'b1;
    while (!m0.awready && n < 50) begin tick(); n++; end
    chk("aw_ready", m0.awready, 1);
    tick();
    m0.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    m0.wdata = d;
    m0.wstrb = s;
    m0.wvalid = 1'b1;
    while (!m0.wready && n < 50) begin tick(); n++; end
    chk("w_ready", m0.wready, 1);
    tick();
    m0.wvalid = 1'b0;
  endtask

  task automatic wait_b(input int hold);
    int n = 0;
    while (!m0.bvalid && n < 50) begin tick(); n++; end
    chk("b_wait", n < 50, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("b_hold", m0.bvalid, 1);
    end
    m0.bready = 1'b1;
    tick();
    m0.bready = 1'b0;
    chk("b_drop", m0.bvalid, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    bq.push_back(r);
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b(0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [33:0] e);
    int n = 0;
    rq.push_back(e);
    m0.araddr = a;
    m0.arvalid = 1'b1;
    while (!m0.arready && n < 50) begin tick(); n++; end
    chk("ar_ready", m0.arready, 1);
    tick();
    m0.arvalid = 1'b0;
    m0.rready = 1'b1;
    n = 0;
    while (!m0.rvalid && n < 50) begin tick(); n++; end
    chk("r_wait", n < 50, 1);
    tick();
    m0.rready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    {m0.awaddr, m0.awvalid, m0.wdata, m0.wstrb, m0.wvalid, m0.bready, m0.araddr, m0.arvalid, m0.rready} = '0;
    {m1.awaddr, m1.awvalid, m1.wdata, m1.wstrb, m1.wvalid, m1.bready, m1.araddr, m1.arvalid, m1.rready} = '0;
    ri0 = '0;
    ri0[2] = 32'h1234_5678;
    ri1 = '0;
    for (int i = 0; i < 16; i++) begin wp_cnt[i] = 0; rp_cnt[i] = 0; end
    tick();
    tick();
    chk("rst_awready", m0.awready, 0);
    chk("rst_arready", m0.arready, 0);
    chk("rst_bvalid", m0.bvalid, 0);
    chk("rst_rvalid", m0.rvalid, 0);
    chk("rst_regs", ro0 == '0, 1);
    rst0_n = 1'b1;
    tick();
    chk("rel_readies", {m0.awready, m0.wready, m0.arready}, 3'b111);
    wr(32'h1004, 32'hDEAD_BEEF, 4'hF, 2'b00);
    chk("reg1_full", ro0[1], 32'hDEAD_BEEF);
    chk("wp1_once", wp_cnt[1], 1);
    rd(32'h1004, {2'b00, 32'hDEAD_BEEF});
    chk("rp1_once", rp_cnt[1], 1);
    wr(32'h1006, 32'h00AB_0000, 4'b0100, 2'b00);
    chk("reg1_byte", ro0[1], 32'hDEAB_BEEF);
    rd(32'h1006, {2'b00, 32'hDEAB_BEEF});
    bq.push_back(2'b00);
    send_w(32'h1122_3344, 4'hF);
    chk("wready_drop", m0.wready, 0);
    tick();
    tick();
    chk("w_first_no_commit", {m0.bvalid, ro0[0]}, 33'h0);
    send_aw(32'h1000);
    wait_b(0);
    chk("reg0_split", ro0[0], 32'h1122_3344);
    bq.push_back(2'b00);
    send_aw(32'h100C);
    chk("awready_drop", m0.awready, 0);
    tick();
    tick();
    chk("aw_first_no_commit", ro0[3], 32'h0);
    send_w(32'h5566_7788, 4'hF);
    wait_b(5);
    chk("reg3_split", ro0[3], 32'h5566_7788);
    chk("split_pulses", {wp_cnt[0][7:0], wp_cnt[3][7:0]}, 16'h0101);
    rd(32'h1008, {2'b00, 32'h1234_5678});
    chk("rp2_once", rp_cnt[2], 1);
    wr(32'h1008, 32'hFFFF_FFFF, 4'hF, 2'b10);
    chk("ro_no_pulse", wp_cnt[2], 0);
    rd(32'h1008, {2'b00, 32'h1234_5678});
    rd(32'h0FFC, {2'b10, 32'h0});
    rd(32'h1040, {2'b10, 32'h0});
    wr(32'h1040, 32'hCAFE_F00D, 4'hF, 2'b10);
    wr(32'h1000, 32'hFFFF_FFFF, 4'h0, 2'b00);
    chk("strb0_no_change", ro0[0], 32'h1122_3344);
    chk("strb0_no_pulse", wp_cnt[0], 1);
    bq.push_back(2'b00);
    fork
      begin
        fork
          send_aw(32'h100C);
          send_w(32'hA5A5_A5A5, 4'hF);
        join
        wait_b(0);
      end
      rd(32'h100C, {2'b00, 32'h5566_7788});
    join
    chk("reg3_after_rdw", ro0[3], 32'hA5A5_A5A5);
    chk("wp3_total", wp_cnt[3], 2);
    chk("r_queue_empty", rq.size(), 0);
    chk("b_queue_empty", bq.size(), 0);

    rst1_n = 1'b1;
    tick();
    tick();
    chk("u1_arready", m1.arready, 1);
    m1.araddr = 32'h1000;
    m1.arvalid = 1'b1;
    tick();
    m1.arvalid = 1'b0;
    m1.rready = 1'b1;
    n = 0;
    while (!m1.rvalid && n < 300) begin tick(); n++; end
    chk("u1_rd_delay", n + 1, 201);
    chk("u1_rd_pulse", rp1[0], 1);
    chk("u1_rdata0", {m1.rresp, m1.rdata}, {2'b00, 32'h0});
    tick();
    m1.rready = 1'b0;
    chk("u1_rd_pulse_len", rp1[0], 0);
    m1.awaddr = 32'h1000;
    m1.wdata = 32'hDEAD_BEEF;
    m1.wstrb = 4'hF;
    m1.awvalid = 1'b1;
    m1.wvalid = 1'b1;
    tick();
    m1.awvalid = 1'b0;
    m1.wvalid = 1'b0;
    chk("u1_reg0", ro1[0], 32'hDEAD_BEEF);
    n = 0;
    while (!m1.bvalid && n < 300) begin tick(); n++; end
    chk("u1_b_delay", n + 1, 201);
    #3;
    rst1_n = 1'b0;
    #1;
    chk("u1_bvalid_async", m1.bvalid, 0);
    chk("u1_regs_clear", ro1 == '0, 1);
    tick();
    chk("u1_arready_rst", m1.arready, 0);
    rst1_n = 1'b1;
    tick();
    tick();
    m1.araddr = 32'h1000;
    m1.arvalid = 1'b1;
    tick();
    m1.arvalid = 1'b0;
    m1.rready = 1'b1;
    n = 0;
    while (!m1.rvalid && n < 300) begin tick(); n++; end
    chk("u1_rd_wait", n < 300, 1);
    chk("u1_rdata_after_rst", {m1.rresp, m1.rdata}, {2'b00, 32'h0});
    tick();
    m1.rready = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
